// File: rtl/uc_mc.sv
// uc_mc: multicycle control unit for the polirv core (fetch/decode/exec/mem/wb with traps).
// Define UC_MC_PERF_EN to build the retired-instruction counter; otherwise instret is tied to 0.
module uc_mc #(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             funct7_5,
    input  logic             alu_zero,
    output logic             i_mem_req,
    input  logic             i_mem_ack,
    output logic             d_mem_req,
    input  logic             d_mem_ack,
    output logic             d_mem_we,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pc_src,
    output logic             rf_we,
    output logic [1:0]       rf_src,
    output logic             alu_src,
    output logic [3:0]       alu_cmd,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instret,
    output logic [2:0]       dbg_state
);

    // Handshake: i_mem_req / d_mem_req rise in FETCH / MEM and stay high until the
    // matching ack; a transfer completes in any cycle where req && ack are both high.

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    state_t     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic [1:0] cause_q, cause_d;
    logic       run_q;

    logic is_r, is_i, is_ld, is_sd, is_br, is_jal, legal, br_taken;

    assign is_r     = (opcode == OP_R);
    assign is_i     = (opcode == OP_I);
    assign is_ld    = (opcode == OP_LD);
    assign is_sd    = (opcode == OP_SD);
    assign is_br    = (opcode == OP_BR);
    assign is_jal   = (opcode == OP_JAL);
    assign legal    = is_r | is_i | is_ld | is_sd | is_br | is_jal;
    assign br_taken = ((funct3 == 3'b000) && alu_zero) || ((funct3 == 3'b001) && !alu_zero);

    // run_q keeps every output at 0 until the first clock after rst is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
            cause_q <= 2'b00;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cause_q <= cause_d;
            run_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = '0;
        cause_d   = cause_q;
        i_mem_req = 1'b0;
        d_mem_req = 1'b0;
        d_mem_we  = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_src    = 1'b0;
        rf_we     = 1'b0;
        rf_src    = 2'b00;
        alu_src   = 1'b0;
        alu_cmd   = 4'b0000;
        trap      = 1'b0;

        if (run_q) begin
            case (state_q)
                S_FETCH: begin
                    i_mem_req = 1'b1;
                    if (i_mem_ack) begin
                        ir_we   = 1'b1;
                        pc_we   = 1'b1;
                        state_d = S_DECODE;
                    // wait_q counts completed wait cycles; MAX_WAIT of them are tolerated.
                    end else if (wait_q == WAIT_LIMIT) begin
                        state_d = S_TRAP;
                        cause_d = 2'b10;
                    end else begin
                        wait_d = wait_q + 8'd1;
                    end
                end

                S_DECODE: begin
                    if (legal) begin
                        state_d = S_EXEC;
                    end else begin
                        state_d = S_TRAP;
                        cause_d = 2'b01;
                    end
                end

                S_EXEC: begin
                    if (is_r) begin
                        alu_cmd = {funct7_5, funct3};
                        state_d = S_WB;
                    end else if (is_i) begin
                        alu_cmd = (funct3 == 3'b101) ? {funct7_5, funct3} : {1'b0, funct3};
                        alu_src = 1'b1;
                        state_d = S_WB;
                    end else if (is_ld || is_sd) begin
                        alu_src = 1'b1;
                        state_d = S_MEM;
                    end else if (is_br) begin
                        alu_cmd = 4'b1000;
                        pc_we   = br_taken;
                        pc_src  = br_taken;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end

                S_MEM: begin
                    d_mem_req = 1'b1;
                    d_mem_we  = is_sd;
                    alu_src   = 1'b1;
                    if (d_mem_ack) begin
                        state_d = is_ld ? S_WB : S_FETCH;
                    end else if (wait_q == WAIT_LIMIT) begin
                        state_d = S_TRAP;
                        cause_d = 2'b10;
                    end else begin
                        wait_d = wait_q + 8'd1;
                    end
                end

                S_WB: begin
                    rf_we   = 1'b1;
                    rf_src  = is_ld ? 2'b01 : (is_jal ? 2'b10 : 2'b00);
                    pc_we   = is_jal;
                    pc_src  = is_jal;
                    state_d = S_FETCH;
                end

                S_TRAP: begin
                    trap = 1'b1;
                end

                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

    assign trap_cause = cause_q;
    assign dbg_state  = state_q;

`ifdef UC_MC_PERF_EN
    logic             retire;
    logic [CNT_W-1:0] instret_q;

    assign retire = (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) &&
                    (state_d == S_FETCH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret_q <= '0;
        end else if (retire) begin
            instret_q <= instret_q + 1'b1;
        end
    end

    assign instret = instret_q;
`else
    assign instret = '0;
`endif

endmodule

// File: doc/uc_mc.md
# uc_mc

Multicycle control unit for the polirv core, the successor of the single-cycle `uc`. It sequences fetch, decode, execute, memory and writeback over several cycles. Unlike `uc`, it handshakes with instruction and data memories that may insert wait states, traps on illegal opcodes and memory timeouts, and can optionally count retired instructions. It sits beside the multicycle datapath in the core top level and drives all of its enables and mux selects.

## Interface
- `MAX_WAIT`, default 15: memory wait cycles allowed before a timeout trap (1..255).
- `CNT_W`, default 32: width of the retired-instruction counter.

- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `opcode` in 7: `ir[6:0]` from the datapath.
- `funct3` in 3: `ir[14:12]`.
- `funct7_5` in 1: `ir[30]`.
- `alu_zero` in 1: ALU result is zero.
- `i_mem_req` out 1: instruction fetch request.
- `i_mem_ack` in 1: instruction data valid this cycle.
- `d_mem_req` out 1: data access request.
- `d_mem_ack` in 1: data access complete this cycle.
- `d_mem_we` out 1: store qualifier, valid with `d_mem_req`.
- `ir_we` out 1: load IR and latch `old_pc`.
- `pc_we` out 1: PC write enable.
- `pc_src` out 1: 0 = PC+4, 1 = `old_pc` + imm.
- `rf_we` out 1: register file write.
- `rf_src` out 2: 00 = ALU, 01 = memory, 10 = PC (link).
- `alu_src` out 1: 0 = rs2, 1 = imm.
- `alu_cmd` out 4: ALU operation.
- `trap` out 1: core halted.
- `trap_cause` out 2: 01 = illegal opcode, 10 = memory timeout.
- `instret` out `CNT_W`: retired instruction count.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- Reset: state FETCH; all outputs 0; wait counter 0; `instret` 0.
- **FETCH**
  - `i_mem_req` = 1.
  - On `i_mem_ack`: `ir_we` = 1, `pc_we` = 1, `pc_src` = 0, next state DECODE.
- **DECODE**
  - Supported opcodes: 0110011 (R), 0010011 (I-ALU), 0000011 (LD), 0100011 (SD), 1100011 (branch), 1101111 (JAL).
  - Any other opcode goes to TRAP, cause 01.
- **EXEC, by instruction class**
  - R: `alu_cmd` = {`funct7_5`, `funct3`}, `alu_src` = 0, then WB.
  - I-ALU: `alu_cmd` = {0, `funct3`}, except `funct3` = 101 uses {`funct7_5`, 101}; `alu_src` = 1; then WB.
  - LD/SD: `alu_cmd` = 0000, `alu_src` = 1, then MEM.
  - Branch: `alu_cmd` = 1000 (sub), `alu_src` = 0.
    - Taken when (`funct3` = 000 and `alu_zero`) or (`funct3` = 001 and !`alu_zero`).
    - Taken: `pc_we` = 1, `pc_src` = 1.
    - Other `funct3` values are never taken.
    - Then FETCH.
  - JAL: then WB.
- **MEM**
  - `d_mem_req` = 1; `d_mem_we` = 1 for SD.
  - On `d_mem_ack`: LD goes to WB, SD goes to FETCH.
- **WB**
  - `rf_we` = 1.
  - `rf_src` = 01 for LD, 10 for JAL, 00 otherwise.
  - JAL also asserts `pc_we` = 1, `pc_src` = 1.
  - Then FETCH.
- **TRAP**
  - All strobes and requests are 0; `trap` = 1; `trap_cause` is held.
  - Leaves TRAP only on `rst`.
- **Wait counter**
  - Counts cycles in FETCH/MEM with the request high and ack low.
  - Clears on ack or on state change.
  - When it reaches `MAX_WAIT` without ack: go to TRAP, cause 10.
  - Ack in the same cycle the limit is reached wins; no trap.
- **Retirement:** one instruction retires on entry to FETCH from EXEC, MEM or WB. `instret` wraps at 2^`CNT_W`.
- **Other:** `alu_cmd` and `alu_src` are 0 outside EXEC and MEM.

## Timing
- Outputs are Moore in state, except the ack-qualified strobes `ir_we` and FETCH `pc_we`, which are combinational on `i_mem_ack`.
- Requests are held high until ack; a request never drops before ack.
- Cycles per instruction with zero-wait memory (ack in the request cycle):
  - R / I / JAL: 4.
  - LD: 5.
  - SD: 4.
  - Branch: 3.
- Each memory wait cycle adds 1.
- `rst` asserted mid-instruction: outputs go to 0 asynchronously. The first FETCH request is on the first clock after `rst` falls.

## Configuration
- `UC_MC_PERF_EN` defined: the `instret` counter is implemented as above.
- `UC_MC_PERF_EN` undefined: no counter logic; `instret` is tied to 0.
- All other behaviour is identical in both builds.

## Test plan
- Zero-wait `add x3,x1,x2` (0x002081B3): states F, D, E, WB. `alu_cmd` = 0000, `rf_we` = 1 for one cycle, `instret` 0→1 after 4 cycles.
- LD with `d_mem_ack` delayed 3 cycles: `d_mem_req` high for 4 cycles, then WB with `rf_src` = 01. Total 8 cycles.
- BEQ with `alu_zero` = 1: EXEC asserts `pc_we` = 1, `pc_src` = 1. BNE with `alu_zero` = 1: no `pc_we` in EXEC.
- Opcode 0x7F: TRAP reached on the cycle after DECODE, `trap_cause` = 01, no further requests for 20 cycles. `rst` pulse returns to FETCH.
- `MAX_WAIT` = 3, `i_mem_ack` never asserted: TRAP with cause 10 after 3 wait cycles. Repeat with ack arriving on the limit cycle: no trap.
- `rst` asserted during MEM of an SD: `d_mem_req` and `d_mem_we` drop immediately, `instret` = 0.
